fp16_add_arbiter: RTL and testbench

- Shares one pipelined fp16adder (half-precision add, ports clk, rst, a, b, out) between NREQ requesters in the vertex-multiplier datapath.
- Arbitrates round-robin and issues at most one add or subtract per cycle.
- Tracks requester IDs through the adder pipeline and returns each sum to the requester that issued it.
- Limits outstanding operations per requester with credit counters.

---
 rtl/fp16_pkg.sv | 25 ++
 rtl/fp16_add_arbiter_if.sv | 36 +++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/fp16_add_arbiter.sv | 145 ++++++++++++++
 tb/tb_fp16_add_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fp16_pkg
//  Brief   : Shared half-precision types and pipeline tag definition for the
//            shared-adder arbiter.
//  Revision: 1.0  initial release
// ============================================================================
package fp16_pkg;

  localparam int FP16_W        = 16;
  localparam int FP16_SIGN_BIT = 15;

  // Tag id is sized for the largest supported requester count (8); narrower
  // configurations zero-extend their requester index into it.
  localparam int TAG_IDW       = 3;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fp16_add_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : fp16_add_arbiter_if
//  Brief   : Requester, adder and response bundle for fp16_add_arbiter.
//            "slave" is the arbiter side, "master" the surrounding datapath.
//  Revision: 1.0  initial release
// ============================================================================
interface fp16_add_arbiter_if #(
  parameter int NREQ = 4
);
  import fp16_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*FP16_W-1:0] req_a;
  logic [NREQ*FP16_W-1:0] req_b;
  logic [NREQ-1:0]        req_sub;
  fp16_t                  add_a;
  fp16_t                  add_b;
  fp16_t                  add_sum;
  logic [NREQ-1:0]        rsp_valid;
  fp16_t                  rsp_data;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, add_sum,
    input  req_ready, add_a, add_b, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_sum,
    output req_ready, add_a, add_b, rsp_valid, rsp_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Brief   : Round-robin arbiter. Combinational one-hot grant scanning upward
//            from a rotating pointer; pointer advances past the winner only
//            when the grant is accepted.
//  Revision: 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_pos;

  // First requesting index at or above the pointer, wrapping at NREQ
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_pos >= (IDW+1)'(NREQ)) begin
        w_pos = w_pos - (IDW+1)'(NREQ);
      end
      if (!gnt_any && req[w_pos[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = w_pos[IDW-1:0];
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Move the pointer just past the accepted winner so it gets lowest priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (accept && gnt_any) begin
      r_ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp16_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : fp16_add_arbiter
//  Brief   : Shares one pipelined fp16 adder among NREQ requesters. Issues at
//            most one op per cycle, tags each op with its requester id through
//            the adder latency, routes the sum back, and limits in-flight ops
//            per requester with credit counters.
//  Revision: 1.0  initial release
// ============================================================================
module fp16_add_arbiter
  import fp16_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 3,
  parameter int MAX_OUT = 2,
  parameter int IDW     = 2
) (
  input logic               clk,
  input logic               rst,
  fp16_add_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_OUT + 1);

  if (IDW != $clog2(NREQ) || IDW > TAG_IDW || MAX_OUT < 1 || MAX_OUT > ADD_LAT + 1)
  begin : g_param_check
    $error("fp16_add_arbiter: unsupported parameter combination");
  end

  fp16_t [NREQ-1:0]  w_a_arr;
  fp16_t [NREQ-1:0]  w_b_arr;
  logic  [NREQ-1:0]  w_elig;
  logic  [NREQ-1:0]  w_gnt;
  logic  [NREQ-1:0]  w_hs;
  logic  [IDW-1:0]   w_gnt_idx;
  logic              w_gnt_any;
  tag_t              w_tag_new;
  tag_t              w_tag_out;
  logic              w_busy;

  logic  [CW-1:0]    r_credit [NREQ];
  tag_t  [ADD_LAT:0] r_tag;
  fp16_t             r_add_a;
  fp16_t             r_add_b;
  logic  [NREQ-1:0]  r_rsp_valid;
  fp16_t             r_rsp_data;

  assign w_a_arr = bus.req_a;
  assign w_b_arr = bus.req_b;

  // A requester may compete only while it has credit left; nothing wins in reset
  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign w_elig[i] = bus.req_valid[i] && (r_credit[i] < CW'(MAX_OUT)) && !rst;
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (w_elig),
    .accept  (w_gnt_any),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  assign bus.req_ready = w_gnt;
  assign w_hs          = w_gnt & bus.req_valid;
  assign w_tag_new     = tag_t'({w_gnt_any, TAG_IDW'(w_gnt_idx)});
  assign w_tag_out     = r_tag[ADD_LAT];

  // Capture the winner's operands; subtraction is an add with B's sign flipped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (w_gnt_any) begin
      r_add_a <= w_a_arr[w_gnt_idx];
      r_add_b <= w_b_arr[w_gnt_idx] ^ {bus.req_sub[w_gnt_idx], {FP16_SIGN_BIT{1'b0}}};
    end
  end

  // Requester tags ride alongside the adder so each sum knows its owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[ADD_LAT-1:0], w_tag_new};
    end
  end

  // Register the emerging sum and strobe its owner for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_tag_out.valid ? (NREQ'(1) << w_tag_out.id) : '0;
      if (w_tag_out.valid) begin
        r_rsp_data <= bus.add_sum;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_credit
    // Count ops issued but not yet returned; issue and return together cancel
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_credit[i] <= '0;
      end else begin
        case ({w_hs[i], r_rsp_valid[i]})
          2'b10:   r_credit[i] <= r_credit[i] + CW'(1);
          2'b01:   r_credit[i] <= r_credit[i] - CW'(1);
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end

    a_credit_max : assert property (@(posedge clk) disable iff (rst)
      r_credit[i] <= CW'(MAX_OUT));
    a_credit_min : assert property (@(posedge clk) disable iff (rst)
      !(r_credit[i] == '0 && r_rsp_valid[i] && !w_hs[i]));
  end

  // Busy while any tag is in the pipe or any requester is still owed a result
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k <= ADD_LAT; k++) begin
      w_busy = w_busy | r_tag[k].valid;
    end
    for (int i = 0; i < NREQ; i++) begin
      w_busy = w_busy | (r_credit[i] != '0);
    end
  end

  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fp16_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fp16_add_arbiter
//  Brief   : Directed self-checking bench for fp16_add_arbiter with a
//            behavioural 3-stage fp16 adder standing in for the real unit.
//  Revision: 1.0  initial release
// ============================================================================
module tb_fp16_add_arbiter;
  import fp16_pkg::*;

  localparam int NREQ    = 4;
  localparam int ADD_LAT = 3;
  localparam int MAX_OUT = 2;
  localparam int IDW     = 2;
  localparam int LAT     = ADD_LAT + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp16_add_arbiter_if #(.NREQ(NREQ)) bus ();

  fp16_add_arbiter #(
    .NREQ    (NREQ),
    .ADD_LAT (ADD_LAT),
    .MAX_OUT (MAX_OUT),
    .IDW     (IDW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NREQ-1:0][15:0] a_arr;
  logic [NREQ-1:0][15:0] b_arr;
  assign bus.req_a = a_arr;
  assign bus.req_b = b_arr;

  // ---------------- behavioural fp16 adder (normal numbers only) -----------
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    for (int k = 0; k < e - 15; k++) m = m * 2.0;
    for (int k = 0; k < 15 - e; k++) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic       s;
    int         e;
    real        x;
    logic [9:0] mant;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    x = s ? -r : r;
    e = 15;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    mant = 10'($rtoi((x - 1.0) * 1024.0));
    return {s, 5'(e), mant};
  endfunction

  logic [15:0] sum_pipe [ADD_LAT];
  always @(posedge clk) begin
    sum_pipe[0] <= r2h(h2r(bus.add_a) + h2r(bus.add_b));
    for (int k = 1; k < ADD_LAT; k++) sum_pipe[k] <= sum_pipe[k-1];
  end
  assign bus.add_sum = sum_pipe[ADD_LAT-1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue log: requester id and acceptance edge of every handshake
  int q_id[$];
  int q_edge[$];
  int os2     = 0;
  int max_os2 = 0;

  always @(posedge clk) begin
    if (rst) begin
      q_id.delete();
      q_edge.delete();
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_ready[k] && bus.req_valid[k]) begin
          q_id.push_back(k);
          q_edge.push_back(cyc + 1);
          if (k == 2) os2++;
        end
      end
    end
  end

  // Every response must match the oldest issue, arriving LAT edges later
  always @(negedge clk) begin
    if (rst) begin
      q_id.delete();
      q_edge.delete();
      os2 = 0;
    end else if (bus.rsp_valid != '0) begin
      if (q_id.size() == 0) begin
        check("rsp_spurious", 32'(bus.rsp_valid), 32'd0);
      end else begin
        check("rsp_order", 32'(bus.rsp_valid), 32'(1 << q_id[0]));
        check("rsp_lat", 32'(cyc - q_edge[0]), 32'(LAT));
        void'(q_id.pop_front());
        void'(q_edge.pop_front());
      end
      if (bus.rsp_valid[2]) os2--;
    end
    if (os2 > max_os2) max_os2 = os2;
  end

  // ---------------- stimulus helpers (called at a falling edge) ------------
  task automatic do_op(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b,
                       input logic sub);
    int t;
    a_arr[id]         = a;
    b_arr[id]         = b;
    bus.req_sub[id]   = sub;
    bus.req_valid[id] = 1'b1;
    #1;
    t = 0;
    while (!bus.req_ready[id] && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check("issue_timeout", 32'(t < 20), 32'd1);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [3:0] v, output logic [15:0] d);
    int t;
    t = 0;
    while (bus.rsp_valid == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rsp_timeout", 32'(t < 20), 32'd1);
    v = bus.rsp_valid;
    d = bus.rsp_data;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (bus.busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  // ---------------- directed test sequence ----------------
  logic [3:0]  v;
  logic [15:0] d;
  int          t;
  int          exp_idx;
  int          cnt [NREQ];

  initial begin
    bus.req_valid = '1;
    bus.req_sub   = '0;
    a_arr         = '0;
    b_arr         = '0;
    #1 rst = 1'b1;

    // Reset state, with every requester asking
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    check("rst_add_b", 32'(bus.add_b), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 + 2.0 = 3.0
    do_op(2'd0, 16'h3C00, 16'h4000, 1'b0);
    check("add_a", 32'(bus.add_a), 32'h3C00);
    check("add_b", 32'(bus.add_b), 32'h4000);
    check("busy_inflight", 32'(bus.busy), 32'd1);
    wait_rsp(v, d);
    check("add_rsp_valid", 32'(v), 32'b0001);
    check("add_rsp_data", 32'(d), 32'h4200);

    // 1.0 - 2.0 = -1.0
    do_op(2'd1, 16'h3C00, 16'h4000, 1'b1);
    check("sub_add_b", 32'(bus.add_b), 32'hC000);
    wait_rsp(v, d);
    check("sub_rsp_valid", 32'(v), 32'b0010);
    check("sub_rsp_data", 32'(d), 32'hBC00);
    check("idle_busy", 32'(bus.busy), 32'd0);
    bus.req_sub = '0;

    // Fairness: last grant was requester 1, so rotation starts at 2
    for (int k = 0; k < NREQ; k++) cnt[k] = 0;
    exp_idx       = 2;
    bus.req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), 32'(1 << exp_idx));
      for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) cnt[k]++;
      exp_idx = (exp_idx + 1) % NREQ;
      @(negedge clk);
    end
    bus.req_valid = '0;
    for (int k = 0; k < NREQ; k++) check("rr_count", 32'(cnt[k]), 32'd10);
    drain("rr_drain");

    // Credit limit: requester 2 alone gets two accepts then waits for a return
    max_os2       = 0;
    bus.req_valid = 4'b0100;
    #1;
    check("cr_ready0", 32'(bus.req_ready), 32'b0100);
    @(negedge clk); #1;
    check("cr_ready1", 32'(bus.req_ready), 32'b0100);
    @(negedge clk); #1;
    t = 0;
    while (bus.rsp_valid[2] == 1'b0 && t < 20) begin
      check("cr_throttle", 32'(bus.req_ready), 32'd0);
      @(negedge clk); #1;
      t++;
    end
    check("cr_rsp_seen", 32'(t < 20), 32'd1);
    check("cr_ready_at_rsp", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    drain("cr_drain");
    check("cr_max_outstanding", 32'(max_os2), 32'd2);

    // Mixed stream: 3.0+24.0=27.0 on req0, 14.75+7.0=21.75 on req3
    a_arr[0]      = 16'h4200;
    b_arr[0]      = 16'h4E00;
    a_arr[3]      = 16'h4B60;
    b_arr[3]      = 16'h4700;
    bus.req_valid = 4'b1001;
    #1;
    check("mix_grant0", 32'(bus.req_ready), 32'b1000);
    @(negedge clk); #1;
    check("mix_grant1", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp(v, d);
    check("mix_rsp0_valid", 32'(v), 32'b1000);
    check("mix_rsp0_data", 32'(d), 32'h4D70);
    wait_rsp(v, d);
    check("mix_rsp1_valid", 32'(v), 32'b0001);
    check("mix_rsp1_data", 32'(d), 32'h4EC0);
    drain("mix_drain");

    // Reset with three ops in flight
    bus.req_valid = 4'b0111;
    repeat (3) @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = '0;
    #1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      check("mrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("mrst_idle", 32'(bus.busy), 32'd0);
    do_op(2'd1, 16'h3C00, 16'h4000, 1'b0);
    wait_rsp(v, d);
    check("mrst_rsp_valid_after", 32'(v), 32'b0010);
    check("mrst_rsp_data_after", 32'(d), 32'h4200);
    drain("final_drain");
    check("no_lost_rsp", 32'(q_id.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
